// File: rtl/arbitro_reg.sv
// Two-requester round-robin arbiter in front of a 4x8 register-bank write port.
// Accepted writes appear on the bank port exactly one cycle later and are counted when they commit.
module arbitro_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lock,
  input  logic       req0_valid,
  input  logic [1:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [1:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       bank_we,
  output logic [1:0] bank_waddr,
  output logic [7:0] bank_wdata,
  output logic [3:0] pending,
  output logic       last_grant,
  output logic [7:0] commit_cnt
);

  logic       prio_q, prio_d;
  logic       last_grant_q, last_grant_d;
  logic       bank_we_q, bank_we_d;
  logic [1:0] bank_waddr_q, bank_waddr_d;
  logic [7:0] bank_wdata_q, bank_wdata_d;
  logic [7:0] commit_cnt_q, commit_cnt_d;
  logic       grant0, grant1;

  // rst_n gates the readys so nothing looks accepted while the block is held in reset
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && !lock) begin
      grant0 = req0_valid && (!req1_valid || (prio_q == 1'b0));
      grant1 = req1_valid && (!req0_valid || (prio_q == 1'b1));
    end
  end

  always_comb begin
    prio_d       = prio_q;
    last_grant_d = last_grant_q;
    bank_we_d    = grant0 || grant1;
    bank_waddr_d = bank_waddr_q;
    bank_wdata_d = bank_wdata_q;
    commit_cnt_d = commit_cnt_q + {7'd0, bank_we_q};
    if (grant0) begin
      bank_waddr_d = req0_addr;
      bank_wdata_d = req0_data;
      last_grant_d = 1'b0;
      prio_d       = 1'b1;
    end else if (grant1) begin
      bank_waddr_d = req1_addr;
      bank_wdata_d = req1_data;
      last_grant_d = 1'b1;
      prio_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q       <= 1'b0;
      last_grant_q <= 1'b0;
      bank_we_q    <= 1'b0;
      bank_waddr_q <= 2'd0;
      bank_wdata_q <= 8'd0;
      commit_cnt_q <= 8'd0;
    end else begin
      prio_q       <= prio_d;
      last_grant_q <= last_grant_d;
      bank_we_q    <= bank_we_d;
      bank_waddr_q <= bank_waddr_d;
      bank_wdata_q <= bank_wdata_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  always_comb begin
    pending = 4'b0000;
    if (bank_we_q) begin
      pending = 4'b0001 << bank_waddr_q;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign bank_we    = bank_we_q;
  assign bank_waddr = bank_waddr_q;
  assign bank_wdata = bank_wdata_q;
  assign last_grant = last_grant_q;
  assign commit_cnt = commit_cnt_q;

endmodule

// File: doc/arbitro_reg.md
ARBITRO_REG -- requirements
Module: arbitro_reg

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: lock  input  1  when 1, no new write is accepted.
REQ-004 SHALL have ports: req0_valid  input  1; req0_addr  input  2; req0_data  input  8  (ALU writeback requester).
REQ-005 SHALL have port: req0_ready  output  1  request 0 accepted this cycle.
REQ-006 SHALL have ports: req1_valid  input  1; req1_addr  input  2; req1_data  input  8  (memory-load requester).
REQ-007 SHALL have port: req1_ready  output  1  request 1 accepted this cycle.
REQ-008 SHALL have ports: bank_we  output  1; bank_waddr  output  2; bank_wdata  output  8  (register-bank write port).
REQ-009 SHALL have port: pending  output  4  one-hot register index being written this cycle.
REQ-010 SHALL have port: last_grant  output  1  index of the most recently accepted requester.
REQ-011 SHALL have port: commit_cnt  output  8  count of committed writes.

Function
REQ-012 Transfer SHALL occur on a rising edge where reqN_valid=1 and reqN_ready=1; requester holds valid/addr/data stable until then.
REQ-013 readyN SHALL be combinational: 0 when lock=1 or reqN_valid=0; otherwise 1 if the other requester is idle or prio=N.
REQ-014 At most one ready SHALL be 1 per cycle; a ready SHALL never be 1 without its valid.
REQ-015 prio (1-bit round-robin pointer) SHALL become the non-granted index after each transfer, and hold otherwise.
REQ-016 On transfer, last_grant SHALL take the granted index at the same edge.
REQ-017 Output stage SHALL be registered: the cycle after a transfer, bank_we=1 and bank_waddr/bank_wdata equal the accepted addr/data.
REQ-018 A cycle without transfer SHALL yield bank_we=0 next cycle; bank_waddr/bank_wdata hold their last values.
REQ-019 Throughput SHALL be one write per cycle; accept-to-bank-write latency SHALL be exactly one cycle.
REQ-020 pending SHALL equal one-hot(bank_waddr) when bank_we=1, else 4'b0000.
REQ-021 commit_cnt SHALL increment by 1 at every edge where bank_we=1, wrapping 255->0.
REQ-022 lock=1 SHALL block new transfers only; a write already in the output stage SHALL still commit.
REQ-023 With lock=0 and both valid continuously, grants SHALL alternate; no requester waits more than one cycle.
REQ-024 Both requesters targeting the same address SHALL be serialized; the bank ends with the later-granted data.
REQ-025 lock asserted and released SHALL not alter prio.

Reset
REQ-026 While rst_n=0, bank_we, bank_waddr, bank_wdata, pending, last_grant, commit_cnt, prio SHALL be 0 and both readys SHALL be 0.
REQ-027 Reset assertion SHALL take effect immediately, without a clock edge; an in-flight write SHALL be dropped.
REQ-028 After rst_n rises, the first contended cycle SHALL grant requester 0.

Verification
REQ-029 Single write: req0 valid addr=2 data=8'hA5 for one cycle -> req0_ready=1; next cycle bank_we=1, waddr=2, wdata=A5, pending=0100; commit_cnt 0->1.
REQ-030 Contention: both valid continuously for 4 cycles after reset -> grant order 0,1,0,1; four consecutive bank_we=1 cycles; commit_cnt=4.
REQ-031 Same address: req0 (3,8'h11) and req1 (3,8'h22) together -> two writes to reg 3, 8'h11 then 8'h22.
REQ-032 Lock: lock=1 the cycle after a transfer while both valid -> in-flight write commits, both readys 0 until lock=0, then the grant follows prio.
REQ-033 Async reset mid-operation: rst_n low between edges while bank_we=1 -> all outputs 0 immediately; write not counted; post-reset contention grants req0.
REQ-034 Wrap: 256 back-to-back commits -> commit_cnt returns to 0.
